// File: rtl/trigger_pattern_receiver_pkg.sv
// Shared types and helpers for the trigger link receive side.
package trig_pkg;

   localparam int TRIG_WIDTH = 10;

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCKED
   } rx_state_t;

   // The generator sends d0 first, then d9 down to d1. An aligned window
   // (oldest bit in the MSB) therefore holds {d0, d9..d1}.
   function automatic logic [TRIG_WIDTH-1:0] rot_expected(input logic [TRIG_WIDTH-1:0] word);
      return {word[0], word[TRIG_WIDTH-1:1]};
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit.
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw bit through the chain; MSB is the settled output.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Chain register, cleared to 0 on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trigger_pattern_receiver.sv
// Trigger link receiver: recovers word alignment of the inverted rotating
// pattern, declares lock, and reports per-frame strobes and mismatches.
module trigger_pattern_receiver
   import trig_pkg::*;
#(
   parameter int WIDTH       = TRIG_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 3,
   parameter int MISS_LIMIT  = 2,
   parameter int ERR_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             line_in,
   input  logic             enable,
   input  logic [WIDTH-1:0] expected,
   input  logic             clear_err,
   output logic             locked,
   output logic             frame_strobe,
   output logic             mismatch,
   output logic [WIDTH-1:0] rx_word,
   output logic [ERR_W-1:0] err_count
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int MC_W  = $clog2(LOCK_COUNT + 1);
   localparam int MS_W  = $clog2(MISS_LIMIT + 1);

   logic             line_s;
   logic             bit_s;
   logic [WIDTH-1:0] exp_rot;
   logic             hit;
   logic             boundary;
   logic             err_inc;

   rx_state_t        state_q, state_d;
   logic [WIDTH-1:0] w_q, w_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
   logic [MS_W-1:0]  miss_cnt_q, miss_cnt_d;
   logic             locked_q, locked_d;
   logic             frame_strobe_q, frame_strobe_d;
   logic             mismatch_q, mismatch_d;
   logic [WIDTH-1:0] rx_word_q, rx_word_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (line_in),
      .q     (line_s)
   );

   // Line is inverted on the wire.
   assign bit_s    = ~line_s;
   assign exp_rot  = rot_expected(expected);
   assign hit      = (w_q == exp_rot);
   assign boundary = (bit_cnt_q == CNT_W'(WIDTH - 1));

   // Alignment FSM, frame counters, pulse outputs and error counter.
   always_comb begin
      w_d            = {w_q[WIDTH-2:0], bit_s};
      state_d        = state_q;
      bit_cnt_d      = boundary ? '0 : bit_cnt_q + 1'b1;
      match_cnt_d    = match_cnt_q;
      miss_cnt_d     = miss_cnt_q;
      frame_strobe_d = 1'b0;
      mismatch_d     = 1'b0;
      rx_word_d      = rx_word_q;
      err_inc        = 1'b0;

      if (!enable) begin
         state_d     = HUNT;
         bit_cnt_d   = '0;
         match_cnt_d = '0;
         miss_cnt_d  = '0;
      end else begin
         case (state_q)
            HUNT: begin
               // Any phase is tried; a hit fixes the frame boundary here.
               if (hit) begin
                  match_cnt_d = MC_W'(1);
                  miss_cnt_d  = '0;
                  bit_cnt_d   = '0;
                  state_d     = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
               end
            end
            VERIFY: begin
               if (boundary) begin
                  if (hit) begin
                     match_cnt_d = match_cnt_q + 1'b1;
                     if (match_cnt_d == MC_W'(LOCK_COUNT)) state_d = LOCKED;
                  end else begin
                     match_cnt_d = '0;
                     state_d     = HUNT;
                  end
               end
            end
            LOCKED: begin
               if (boundary) begin
                  if (hit) begin
                     frame_strobe_d = 1'b1;
                     rx_word_d      = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
                     miss_cnt_d     = '0;
                  end else begin
                     mismatch_d = 1'b1;
                     err_inc    = 1'b1;
                     miss_cnt_d = miss_cnt_q + 1'b1;
                     if (miss_cnt_d == MS_W'(MISS_LIMIT)) begin
                        state_d     = HUNT;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                     end
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      // Clear beats a coincident increment; count saturates at all-ones.
      err_count_d = err_count_q;
      if (clear_err)                      err_count_d = '0;
      else if (err_inc && !(&err_count_q)) err_count_d = err_count_q + 1'b1;

      locked_d = (state_d == LOCKED);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= HUNT;
         w_q            <= '0;
         bit_cnt_q      <= '0;
         match_cnt_q    <= '0;
         miss_cnt_q     <= '0;
         locked_q       <= 1'b0;
         frame_strobe_q <= 1'b0;
         mismatch_q     <= 1'b0;
         rx_word_q      <= '0;
         err_count_q    <= '0;
      end else begin
         state_q        <= state_d;
         w_q            <= w_d;
         bit_cnt_q      <= bit_cnt_d;
         match_cnt_q    <= match_cnt_d;
         miss_cnt_q     <= miss_cnt_d;
         locked_q       <= locked_d;
         frame_strobe_q <= frame_strobe_d;
         mismatch_q     <= mismatch_d;
         rx_word_q      <= rx_word_d;
         err_count_q    <= err_count_d;
      end
   end

   assign locked       = locked_q;
   assign frame_strobe = frame_strobe_q;
   assign mismatch     = mismatch_q;
   assign rx_word      = rx_word_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_trigger_pattern_receiver.sv
// Bench for trigger_pattern_receiver: a rotating-generator model drives the
// line frame by frame from a table; expected pulses go into a scoreboard.
module tb_trigger_pattern_receiver;

   localparam int W  = 10;
   localparam int EW = 4;
   localparam logic [W-1:0] PAT = 10'h300;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          line_in = 1'b1;
   logic          enable = 1'b0;
   logic          clear_err = 1'b0;
   logic [W-1:0]  expected = PAT;
   logic          locked, frame_strobe, mismatch;
   logic [W-1:0]  rx_word;
   logic [EW-1:0] err_count;

   always #5 clk = ~clk;

   trigger_pattern_receiver #(
      .WIDTH(W), .SYNC_STAGES(2), .LOCK_COUNT(3), .MISS_LIMIT(2), .ERR_W(EW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .line_in      (line_in),
      .enable       (enable),
      .expected     (expected),
      .clear_err    (clear_err),
      .locked       (locked),
      .frame_strobe (frame_strobe),
      .mismatch     (mismatch),
      .rx_word      (rx_word),
      .err_count    (err_count)
   );

   typedef enum logic [1:0] {EV_NONE, EV_STROBE, EV_MISS} ev_t;

   // Expected pulse: kind, err_count after it, rx_word after a strobe.
   typedef struct {
      ev_t           kind;
      logic [EW-1:0] err;
      logic [W-1:0]  word;
   } sb_t;

   // One frame of stimulus and what it should produce.
   // flip: bit index to corrupt (-1 none); en_at/en_val: drive enable at that bit;
   // clr: clear_err during bits 0..4; ev: pulse this frame's compare yields;
   // lk: locked value seen at bit 9 of this frame.
   typedef struct {
      int  flip;
      int  en_at;
      bit  en_val;
      bit  clr;
      ev_t ev;
      bit  lk;
   } vec_t;

   sb_t           sbq[$];
   vec_t          vec[$];
   int            checks = 0;
   int            errors = 0;
   logic [EW-1:0] exp_err = '0;
   logic [W-1:0]  gen;
   sb_t           mon_s;
   logic [1:0]    mon_want;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input int flip, input int en_at, input bit en_val,
                      input bit clr, input ev_t ev, input bit lk);
      vec_t v;
      v.flip = flip; v.en_at = en_at; v.en_val = en_val;
      v.clr = clr; v.ev = ev; v.lk = lk;
      vec.push_back(v);
   endtask

   // Pulse monitor: every strobe/mismatch must match the next expectation.
   always @(negedge clk) begin
      if (rst_n && (frame_strobe || mismatch)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", {30'd0, frame_strobe, mismatch}, 32'd0);
         end else begin
            mon_s    = sbq.pop_front();
            mon_want = (mon_s.kind == EV_STROBE) ? 2'b10 : 2'b01;
            chk("pulse_kind", {30'd0, frame_strobe, mismatch}, {30'd0, mon_want});
            chk("pulse_err_count", {28'd0, err_count}, {28'd0, mon_s.err});
            if (mon_s.kind == EV_STROBE)
               chk("rx_word", {22'd0, rx_word}, {22'd0, mon_s.word});
         end
      end
   end

   // Send one generator frame (d0, d9 .. d1, inverted on the line).
   task automatic send_frame(input vec_t v, input bit nxt_clr);
      logic [EW-1:0] err_chk;
      sb_t           s;
      err_chk = exp_err;
      if (v.ev == EV_MISS && exp_err != '1) exp_err = exp_err + 1'b1;
      if (nxt_clr) exp_err = '0;
      if (v.ev != EV_NONE) begin
         s.kind = v.ev; s.err = exp_err; s.word = PAT;
         sbq.push_back(s);
      end
      gen = PAT;
      for (int b = 0; b < W; b++) begin
         @(negedge clk);
         if (b == W - 1) begin
            chk("locked", {31'd0, locked}, {31'd0, v.lk});
            chk("err_count", {28'd0, err_count}, {28'd0, err_chk});
         end
         if (v.en_at >= 0 && !v.en_val && b == v.en_at + 1)
            chk("locked_after_disable", {31'd0, locked}, 32'd0);
         if (b == v.en_at) enable = v.en_val;
         clear_err = v.clr && (b < 5);
         line_in   = ~gen[0] ^ (b == v.flip);
         gen       = {gen[W-2:0], gen[W-1]};
      end
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         send_frame(vec[i], (i < hi) ? vec[i+1].clr : 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
      chk({tag, "_frame_strobe"}, {31'd0, frame_strobe}, 32'd0);
      chk({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
      chk({tag, "_rx_word"}, {22'd0, rx_word}, 32'd0);
      chk({tag, "_err_count"}, {28'd0, err_count}, 32'd0);
   endtask

   // Reset asserted in the middle of a frame while locked.
   task automatic reset_mid_frame();
      gen = PAT;
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         line_in = ~gen[0];
         gen     = {gen[W-2:0], gen[W-1]};
      end
      @(negedge clk);
      chk("pre_reset_locked", {31'd0, locked}, 32'd1);
      chk("pre_reset_err", {28'd0, err_count}, {28'd0, exp_err});
      chk("pre_reset_sb_empty", sbq.size(), 32'd0);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      repeat (3) @(negedge clk);
      check_reset_outputs("held_reset");
      rst_n   = 1'b1;
      exp_err = '0;
   endtask

   initial begin
      // Reset and first lock (frames 0..5).
      for (int k = 0; k < 3; k++) add(-1, -1, 1'b1, 1'b0, EV_NONE, 1'b0);
      for (int k = 0; k < 3; k++) add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);
      // Single flipped bit: one mismatch, lock held.
      add(4, -1, 1'b1, 1'b0, EV_MISS, 1'b1);
      add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);
      add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);
      // Clear, then two corrupted frames drop lock; clean line relocks.
      add(-1, -1, 1'b1, 1'b1, EV_STROBE, 1'b1);
      add(2, -1, 1'b1, 1'b0, EV_MISS, 1'b1);
      add(7, -1, 1'b1, 1'b0, EV_MISS, 1'b1);
      add(-1, -1, 1'b1, 1'b0, EV_NONE, 1'b0);
      add(-1, -1, 1'b1, 1'b0, EV_NONE, 1'b0);
      add(-1, -1, 1'b1, 1'b0, EV_NONE, 1'b0);
      add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);
      add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);
      // Saturation: 18 isolated errors, then clear coincident with an error.
      add(-1, -1, 1'b1, 1'b1, EV_STROBE, 1'b1);
      for (int k = 0; k < 18; k++) begin
         add(k % W, -1, 1'b1, 1'b0, EV_MISS, 1'b1);
         add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);
      end
      add(3, -1, 1'b1, 1'b0, EV_MISS, 1'b1);
      add(-1, -1, 1'b1, 1'b1, EV_STROBE, 1'b1);
      add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);
      // Disable mid-frame while locked, re-enable, relock; then one error.
      add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);
      add(-1, 5, 1'b0, 1'b0, EV_NONE, 1'b0);
      add(-1, -1, 1'b0, 1'b0, EV_NONE, 1'b0);
      add(-1, 5, 1'b1, 1'b0, EV_NONE, 1'b0);
      add(-1, -1, 1'b1, 1'b0, EV_NONE, 1'b0);
      add(-1, -1, 1'b1, 1'b0, EV_NONE, 1'b0);
      add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);
      add(6, -1, 1'b1, 1'b0, EV_MISS, 1'b1);
      add(-1, -1, 1'b1, 1'b0, EV_STROBE, 1'b1);

      enable = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      run_range(0, vec.size() - 1);
      reset_mid_frame();
      run_range(0, 5);

      repeat (6) @(negedge clk);
      chk("sb_drained", sbq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
